// File: rtl/dma_write_burst_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dma_write_burst_scheduler                                  |
// | Description : Round-robin scheduler that shares one AXI4 DMA write       |
// |               master between N_CH source FIFOs. A channel is granted     |
// |               once its FIFO holds a full burst. One burst command        |
// |               (channel, address) is issued at a time. Each channel owns  |
// |               a ring region; region_done pulses when a ring wraps.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   m00_axi_aclk    in   clock                                             |
// |   m00_axi_areset  in   asynchronous reset, active-high                   |
// |   enable          in   scheduler run enable                              |
// |   ch_rd_count     in   FIFO read counts, channel k at [k*CNT_W +: CNT_W] |
// |   burst_start     out  one-cycle pulse, AXI master starts the burst      |
// |   burst_addr      out  burst byte address, valid while busy             |
// |   burst_ch        out  granted channel, valid while busy                 |
// |   burst_done      in   one-cycle pulse, B response accepted              |
// |   burst_err       in   BRESP not OKAY, sampled with burst_done           |
// |   err_clear       in   clears sticky error bits status[2:1]              |
// |   region_done     out  one-cycle pulse per channel on ring wrap          |
// |   sched_status    out  [0] busy [1] bresp err [2] timeout                |
// |                        [6:4] last grant [31:16] burst count              |
// +--------------------------------------------------------------------------+
// | Configuration                                                            |
// |   DMA_SCHED_TIMEOUT_EN : when defined, a WAIT watchdog of TIMEOUT_CYC    |
// |                          cycles sets status[2] and forces UPDATE.        |
// +--------------------------------------------------------------------------+
module dma_write_burst_scheduler #(
   parameter int          N_CH        = 2,
   parameter int          BURST_LEN   = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          REGION_SIZE = 8192000,
   parameter int          CNT_W       = 15,
   parameter int          TIMEOUT_CYC = 4096,
   localparam int         CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  m00_axi_aclk,
   input  logic                  m00_axi_areset,
   input  logic                  enable,
   input  logic [N_CH*CNT_W-1:0] ch_rd_count,
   output logic                  burst_start,
   output logic [31:0]           burst_addr,
   output logic [CH_W-1:0]       burst_ch,
   input  logic                  burst_done,
   input  logic                  burst_err,
   input  logic                  err_clear,
   output logic [N_CH-1:0]       region_done,
   output logic [31:0]           sched_status
);

   localparam int c_off_w = $clog2(REGION_SIZE) + 1;
   localparam logic [c_off_w-1:0] c_step   = c_off_w'(BURST_LEN * 4);
   localparam logic [c_off_w-1:0] c_region = c_off_w'(REGION_SIZE);

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_issue  = 2'd1;
   localparam logic [1:0] c_st_wait   = 2'd2;
   localparam logic [1:0] c_st_update = 2'd3;

   logic [1:0]         r_state;
   logic [1:0]         w_next;
   logic [CH_W-1:0]    r_ch;
   logic [CH_W-1:0]    r_last_grant;
   logic [2:0]         r_last_rep;
   logic [c_off_w-1:0] r_offset [N_CH];
   logic               r_err;
   logic               r_tmo;
   logic [15:0]        r_bcount;

   logic [N_CH-1:0]    w_elig;
   logic               w_found;
   logic [CH_W-1:0]    w_winner;
   int                 v_idx;
   logic [c_off_w-1:0] w_off_sum;
   logic               w_wrap;
   logic [31:0]        w_addr;
   logic               w_busy;
   logic               w_timeout;
   logic               w_err_set;

   wire clk = m00_axi_aclk;
   wire rst = m00_axi_areset;

   // Unsigned compare of each FIFO fill level against a full burst
   for (genvar k = 0; k < N_CH; k++) begin : g_elig
      assign w_elig[k] = (ch_rd_count[k*CNT_W +: CNT_W] >= CNT_W'(BURST_LEN));
   end

   // Round-robin search starting one past the last grant, wrapping mod N_CH
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      v_idx    = 0;
      for (int i = 1; i <= N_CH; i++) begin
         v_idx = int'(r_last_grant) + i;
         if (v_idx >= N_CH) v_idx = v_idx - N_CH;
         for (int k = 0; k < N_CH; k++) begin
            if (!w_found && (v_idx == k) && w_elig[k]) begin
               w_found  = 1'b1;
               w_winner = CH_W'(k);
            end
         end
      end
   end

   assign w_off_sum = r_offset[r_ch] + c_step;
   assign w_wrap    = (w_off_sum == c_region);
   assign w_addr    = BASE_ADDR + 32'(r_ch) * 32'(REGION_SIZE) + 32'(r_offset[r_ch]);
   assign w_busy    = (r_state != c_st_idle);
   assign w_err_set = (r_state == c_st_wait) && burst_done && burst_err;

`ifdef DMA_SCHED_TIMEOUT_EN
   localparam int c_tmo_w = $clog2(TIMEOUT_CYC) + 1;
   logic [c_tmo_w-1:0] r_wait_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (r_state == c_st_wait) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
         r_wait_cnt <= '0;
      end
   end

   // The counter holds the number of WAIT cycles already elapsed
   assign w_timeout = (r_state == c_st_wait) && !burst_done &&
                      (r_wait_cnt == c_tmo_w'(TIMEOUT_CYC - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= c_st_idle;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_st_idle:   if (enable && w_found) w_next = c_st_issue;
         c_st_issue:  w_next = c_st_wait;
         c_st_wait:   if (burst_done || w_timeout) w_next = c_st_update;
         c_st_update: w_next = c_st_idle;
         default:     w_next = c_st_idle;
      endcase
   end

   // Outputs
   always_comb begin
      burst_start  = (r_state == c_st_issue);
      burst_addr   = w_busy ? w_addr : 32'd0;
      burst_ch     = w_busy ? r_ch : '0;
      region_done  = ((r_state == c_st_update) && w_wrap) ? (N_CH'(1) << r_ch) : '0;
      sched_status = {r_bcount, 9'd0, r_last_rep, 1'b0, r_tmo, r_err, w_busy};
   end

   // Datapath: grant latch, ring pointers, sticky status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ch         <= '0;
         r_last_grant <= CH_W'(N_CH - 1);
         r_last_rep   <= 3'd0;
         r_err        <= 1'b0;
         r_tmo        <= 1'b0;
         r_bcount     <= 16'd0;
         for (int k = 0; k < N_CH; k++) r_offset[k] <= '0;
      end else begin
         if ((r_state == c_st_idle) && (w_next == c_st_issue)) r_ch <= w_winner;
         // Pointer advances even after an error: the FIFO data is already gone
         if (r_state == c_st_update) begin
            r_offset[r_ch] <= w_wrap ? '0 : w_off_sum;
            r_bcount       <= r_bcount + 16'd1;
            r_last_grant   <= r_ch;
            r_last_rep     <= 3'(r_ch);
         end
         // A new event in the same cycle as err_clear is kept
         r_err <= w_err_set | (r_err & ~err_clear);
         r_tmo <= w_timeout | (r_tmo & ~err_clear);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dma_write_burst_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
module tb_dma_write_burst_scheduler;
   localparam int N_CH  = 2;
   localparam int CNT_W = 15;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  enable;
   logic [N_CH*CNT_W-1:0] ch_rd_count;
   logic                  burst_start;
   logic [31:0]           burst_addr;
   logic [0:0]            burst_ch;
   logic                  burst_done;
   logic                  burst_err;
   logic                  err_clear;
   logic [N_CH-1:0]       region_done;
   logic [31:0]           sched_status;

   int checks = 0;
   int errors = 0;
   int n_starts = 0;
   int rd_seen = 0;
   int rd_at = -1;
   int s0;
   logic [32:0] sb_q [$];
   logic [32:0] mon_e;

   always #5 clk = ~clk;

   dma_write_burst_scheduler #(
      .N_CH(N_CH), .BURST_LEN(256), .BASE_ADDR(32'h1000_0000),
      .REGION_SIZE(8192000), .CNT_W(CNT_W), .TIMEOUT_CYC(4096)
   ) dut (
      .m00_axi_aclk(clk), .m00_axi_areset(rst), .enable(enable),
      .ch_rd_count(ch_rd_count), .burst_start(burst_start),
      .burst_addr(burst_addr), .burst_ch(burst_ch), .burst_done(burst_done),
      .burst_err(burst_err), .err_clear(err_clear),
      .region_done(region_done), .sched_status(sched_status)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every burst_start must match the queued command
   always @(negedge clk) begin
      if (burst_start) begin
         n_starts++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual ch=%0d addr=%h required=no burst", burst_ch, burst_addr);
         end else begin
            mon_e = sb_q.pop_front();
            chk("sb_ch", 32'(burst_ch), 32'(mon_e[32]));
            chk("sb_addr", burst_addr, mon_e[31:0]);
         end
      end
      if (region_done != '0) begin
         rd_seen++;
         rd_at = n_starts;
      end
   end

   task automatic set_counts(input int c0, input int c1);
      ch_rd_count = {CNT_W'(c1), CNT_W'(c0)};
   endtask

   task automatic expect_burst(input int ch, input logic [31:0] addr);
      sb_q.push_back({ch[0], addr});
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; burst_done = 1'b0; burst_err = 1'b0; err_clear = 1'b0;
      set_counts(0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (burst_start) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait_start actual=none required=burst_start within 40 cycles");
      end
   endtask

   task automatic give_done(input int dly, input bit err, input bit clr);
      repeat (dly) @(posedge clk);
      #1 burst_done = 1'b1; burst_err = err; err_clear = clr;
      @(posedge clk);
      #1 burst_done = 1'b0; burst_err = 1'b0; err_clear = 1'b0;
   endtask

   task automatic serve(input int n, input int dly, input bit stop);
      bit ok;
      for (int i = 0; i < n; i++) begin
         wait_start(ok);
         give_done(dly, 1'b0, 1'b0);
         if (stop && (i == n - 1)) set_counts(0, 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      rst = 1'b1;
      do_reset();

      // Reset state
      @(negedge clk);
      chk("rst_start", 32'(burst_start), 32'd0);
      chk("rst_addr", burst_addr, 32'd0);
      chk("rst_ch", 32'(burst_ch), 32'd0);
      chk("rst_region", 32'(region_done), 32'd0);
      chk("rst_status", sched_status, 32'd0);

      // Single channel, latency and pointer advance
      enable = 1'b1;
      @(posedge clk);
      #1 set_counts(256, 0);
      expect_burst(0, 32'h1000_0000);
      expect_burst(0, 32'h1000_0400);
      @(negedge clk);
      chk("t1_pre_latency", 32'(burst_start), 32'd0);
      @(negedge clk);
      chk("t1_latency", 32'(burst_start), 32'd1);
      @(posedge clk);
      #1;
      chk("t1_busy", 32'(sched_status[0]), 32'd1);
      chk("t1_addr_hold", burst_addr, 32'h1000_0000);
      burst_done = 1'b1;
      @(posedge clk);
      #1 burst_done = 1'b0;
      serve(1, 2, 1'b1);
      repeat (6) @(posedge clk);
      #1 chk("t1_status", sched_status, 32'h0002_0000);
      // burst_done outside WAIT has no effect
      burst_done = 1'b1; burst_err = 1'b1;
      @(posedge clk);
      #1 burst_done = 1'b0; burst_err = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("t1_done_ignored", sched_status, 32'h0002_0000);

      // Two eligible channels alternate
      do_reset();
      enable = 1'b1;
      expect_burst(0, 32'h1000_0000);
      expect_burst(1, 32'h107D_0000);
      expect_burst(0, 32'h1000_0400);
      expect_burst(1, 32'h107D_0400);
      set_counts(300, 300);
      serve(4, 5, 1'b1);
      repeat (6) @(posedge clk);
      #1 chk("t2_status", sched_status, 32'h0004_0010);

      // Bus error: sticky bit, pointer still advances, set beats clear
      do_reset();
      enable = 1'b1;
      expect_burst(0, 32'h1000_0000);
      expect_burst(0, 32'h1000_0400);
      expect_burst(0, 32'h1000_0800);
      set_counts(256, 0);
      wait_start(ok);
      give_done(2, 1'b1, 1'b0);
      @(negedge clk);
      chk("t4_err_set", 32'(sched_status[1]), 32'd1);
      wait_start(ok);
      give_done(2, 1'b1, 1'b1);
      @(negedge clk);
      chk("t4_set_wins", 32'(sched_status[1]), 32'd1);
      wait_start(ok);
      give_done(2, 1'b0, 1'b0);
      set_counts(0, 0);
      @(posedge clk);
      #1 err_clear = 1'b1;
      @(posedge clk);
      #1 err_clear = 1'b0;
      chk("t4_err_clear", 32'(sched_status[1]), 32'd0);

      // enable dropped mid-burst, then counts one short of a burst
      do_reset();
      enable = 1'b1;
      s0 = n_starts;
      expect_burst(0, 32'h1000_0000);
      set_counts(256, 256);
      wait_start(ok);
      @(posedge clk);
      #1 enable = 1'b0;
      give_done(2, 1'b0, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      chk("t5_one_burst", 32'(n_starts - s0), 32'd1);
      chk("t5_status", sched_status, 32'h0001_0000);
      set_counts(255, 255);
      enable = 1'b1;
      repeat (20) @(posedge clk);
      #1 chk("t5_below_burst", 32'(n_starts - s0), 32'd1);

      // Asynchronous reset during WAIT
      do_reset();
      enable = 1'b1;
      expect_burst(0, 32'h1000_0000);
      set_counts(256, 0);
      wait_start(ok);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_status", sched_status, 32'd0);
      chk("t6_rst_addr", burst_addr, 32'd0);
      chk("t6_rst_start", 32'(burst_start), 32'd0);
      repeat (2) @(posedge clk);
      expect_burst(0, 32'h1000_0000);
      #1 rst = 1'b0;
      serve(1, 2, 1'b1);

      // WAIT without burst_done
      do_reset();
      enable = 1'b1;
      expect_burst(0, 32'h1000_0000);
      set_counts(256, 0);
      wait_start(ok);
      set_counts(0, 0);
      repeat (4000) @(posedge clk);
      #1;
      chk("tmo_early", 32'(sched_status[2:0]), 32'd1);
      repeat (110) @(posedge clk);
      #1;
`ifdef DMA_SCHED_TIMEOUT_EN
      chk("tmo_flag", 32'(sched_status[2]), 32'd1);
`else
      chk("tmo_flag", 32'(sched_status[2:0]), 32'd1);
`endif

      // Ring wrap after 8000 bursts of 1024 B
      do_reset();
      enable = 1'b1;
      s0 = n_starts;
      rd_seen = 0;
      for (int i = 0; i < 8000; i++) expect_burst(0, 32'h1000_0000 + 32'(i) * 32'd1024);
      expect_burst(0, 32'h1000_0000);
      set_counts(256, 0);
      serve(7999, 1, 1'b0);
      chk("t3_no_early_wrap", 32'(rd_seen), 32'd0);
      wait_start(ok);
      give_done(1, 1'b0, 1'b0);
      chk("t3_region_done", 32'(region_done), 32'd1);
      @(posedge clk);
      #1 chk("t3_count", 32'(sched_status[31:16]), 32'd8000);
      serve(1, 1, 1'b1);
      repeat (6) @(posedge clk);
      #1;
      chk("t3_rd_pulses", 32'(rd_seen), 32'd1);
      chk("t3_rd_at", 32'(rd_at - s0), 32'd8000);

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
